dm_sysbus_arbiter: RTL and testbench

// Round-robin arbiter sharing the debug module's single system-bus master port
// (req/gnt/r_valid protocol) between NumReq requesters: SBA engine, abstract-cmd memory access, etc.
// One outstanding transaction at a time. Response routed back to the owning requester only.

---
 rtl/dm_sysbus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_dm_sysbus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_sysbus_arbiter.sv
// ---------------------------------------------------------------------------
// dm_sysbus_arbiter
//
// Purpose:
//   Shares the debug module's single system-bus master port (req/gnt/r_valid
//   protocol) between NumReq requesters using round-robin arbitration. Only one
//   transaction is in flight at a time. The response goes back only to the
//   requester that owns the transaction.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_i/add_i/we_i/    per-requester request, address, write enable,
//   wdata_i/be_i         write data and byte enables (flattened, requester 0
//                        in the least significant slice)
//   gnt_o                one-hot grant to the owner (mirrors master_gnt_i)
//   r_valid_o            one-hot response valid to the owner
//   r_rdata_o            response data, broadcast to all requesters
//   r_err_o              response is a timeout error
//   master_*_o           request side of the shared bus port
//   master_gnt_i         bus grant
//   master_r_valid_i     bus response valid
//   master_r_rdata_i     bus response data
//   busy_o               arbiter is not idle
//
// Configuration:
//   DM_SYSBUS_ARB_TIMEOUT_EN  when defined, a transaction waiting longer than
//                             TimeoutCycles for its response is completed with
//                             r_err_o=1 and zero data. When undefined, r_err_o
//                             is tied low and the arbiter waits indefinitely.
// ---------------------------------------------------------------------------
module dm_sysbus_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_i,
  input  logic [NumReq*BusWidth-1:0]   add_i,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq*BusWidth-1:0]   wdata_i,
  input  logic [NumReq*BusWidth/8-1:0] be_i,
  output logic [NumReq-1:0]            gnt_o,
  output logic [NumReq-1:0]            r_valid_o,
  output logic [BusWidth-1:0]          r_rdata_o,
  output logic                         r_err_o,
  output logic                         master_req_o,
  output logic [BusWidth-1:0]          master_add_o,
  output logic                         master_we_o,
  output logic [BusWidth-1:0]          master_wdata_o,
  output logic [BusWidth/8-1:0]        master_be_o,
  input  logic                         master_gnt_i,
  input  logic                         master_r_valid_i,
  input  logic [BusWidth-1:0]          master_r_rdata_i,
  output logic                         busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BeW  = BusWidth / 8;

  // Parameter sanity: these blocks are intentionally empty and only exist if
  // the instance is misconfigured, which makes the bad configuration visible
  // in the elaborated hierarchy.
  if (NumReq < 2) begin : gen_bad_num_req
  end
  if (TimeoutCycles < 2) begin : gen_bad_timeout
  end

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Req  = 2'd1,
    Wait = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;

  // Unpacked views of the flattened per-requester buses.
  logic [BusWidth-1:0] add_arr   [NumReq];
  logic [BusWidth-1:0] wdata_arr [NumReq];
  logic [BeW-1:0]      be_arr    [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : gen_unpack
    assign add_arr[gi]   = add_i[gi*BusWidth +: BusWidth];
    assign wdata_arr[gi] = wdata_i[gi*BusWidth +: BusWidth];
    assign be_arr[gi]    = be_i[gi*BeW +: BeW];
  end

  // Round-robin pointer advance with wrap at NumReq (not necessarily 2^n).
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
    if (32'(x) == NumReq - 1) return '0;
    else                      return x + 1'b1;
  endfunction

  // Winner search: first asserted request starting at the pointer, wrapping.
  logic            any_req;
  logic            found;
  logic [IdxW-1:0] winner;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  always_comb begin
    any_req  = |req_i;
    found    = 1'b0;
    winner   = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = cand[IdxW-1:0];
      if (!found && req_i[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  // Idle arbitrates with zero latency; afterwards the owner is locked in.
  logic [IdxW-1:0] sel;
  assign sel = (state_q == Idle) ? winner : owner_q;

  // Request fields are only presented while a request is actually on the bus.
  assign master_add_o   = master_req_o ? add_arr[sel]   : '0;
  assign master_we_o    = master_req_o & we_i[sel];
  assign master_wdata_o = master_req_o ? wdata_arr[sel] : '0;
  assign master_be_o    = master_req_o ? be_arr[sel]    : '0;

  assign busy_o = (state_q != Idle);

`ifdef DM_SYSBUS_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout;
  assign timeout = (timer_q == TW'(TimeoutCycles - 1));
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    master_req_o = 1'b0;
    gnt_o        = '0;
    r_valid_o    = '0;
    r_err_o      = 1'b0;
    r_rdata_o    = master_r_rdata_i;

    case (state_q)
      Idle: begin
        master_req_o = any_req;
        if (any_req) begin
          owner_d = winner;
          if (master_gnt_i) begin
            gnt_o[winner] = 1'b1;
            ptr_d         = next_idx(winner);
            state_d       = Wait;
          end else begin
            state_d = Req;
          end
        end
      end

      Req: begin
        master_req_o = req_i[owner_q];
        if (!req_i[owner_q]) begin
          // Requester withdrew before being granted: give up the slot
          // without advancing the pointer.
          state_d = Idle;
        end else if (master_gnt_i) begin
          gnt_o[owner_q] = 1'b1;
          ptr_d          = next_idx(owner_q);
          state_d        = Wait;
        end
      end

      Wait: begin
        if (master_r_valid_i) begin
          r_valid_o[owner_q] = 1'b1;
          state_d            = Idle;
        end
`ifdef DM_SYSBUS_ARB_TIMEOUT_EN
        else if (timeout) begin
          r_valid_o[owner_q] = 1'b1;
          r_err_o            = 1'b1;
          r_rdata_o          = '0;
          state_d            = Idle;
        end
`endif
      end

      default: state_d = Idle;
    endcase
  end

`ifdef DM_SYSBUS_ARB_TIMEOUT_EN
  // Counts cycles spent in Wait; zero on the first Wait cycle.
  assign timer_d = (state_q == Wait && state_d == Wait) ? timer_q + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_dm_sysbus_arbiter.sv
module tb_dm_sysbus_arbiter;

  localparam int NR = 2;
  localparam int BW = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NR-1:0]     req_i;
  logic [NR*BW-1:0]  add_i;
  logic [NR-1:0]     we_i;
  logic [NR*BW-1:0]  wdata_i;
  logic [NR*BW/8-1:0] be_i;
  logic [NR-1:0]     gnt_o;
  logic [NR-1:0]     r_valid_o;
  logic [BW-1:0]     r_rdata_o;
  logic              r_err_o;
  logic              master_req_o;
  logic [BW-1:0]     master_add_o;
  logic              master_we_o;
  logic [BW-1:0]     master_wdata_o;
  logic [BW/8-1:0]   master_be_o;
  logic              master_gnt_i;
  logic              master_r_valid_i;
  logic [BW-1:0]     master_r_rdata_i;
  logic              busy_o;

  dm_sysbus_arbiter #(.NumReq(NR), .BusWidth(BW), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .add_i(add_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Expected bus-side events: grants and responses, in order.
  typedef struct {
    bit          is_rv;
    logic [1:0]  vec;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t sb[$];

  task automatic push_gnt(input logic [1:0] v);
    exp_t e;
    e.is_rv = 1'b0; e.vec = v; e.data = '0; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_rv(input logic [1:0] v, input logic [31:0] d, input bit er);
    exp_t e;
    e.is_rv = 1'b1; e.vec = v; e.data = d; e.err = er;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every grant or response the DUT presents must match the next
  // expected event; anything unexpected (strays) is an error.
  always @(negedge clk_i) begin
    if (rst_ni && (gnt_o != '0 || r_valid_o != '0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: gnt_o=%b r_valid_o=%b expected none", gnt_o, r_valid_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rv) begin
          if (r_valid_o !== e.vec || gnt_o !== 2'b00 || r_rdata_o !== e.data || r_err_o !== e.err) begin
            errors++;
            $display("FAIL rsp: got r_valid_o=%b gnt_o=%b rdata=%h err=%b expected r_valid_o=%b rdata=%h err=%b",
                     r_valid_o, gnt_o, r_rdata_o, r_err_o, e.vec, e.data, e.err);
          end else begin
            $display("rsp  owner=%b rdata=%h err=%b", r_valid_o, r_rdata_o, r_err_o);
          end
        end else begin
          if (gnt_o !== e.vec || r_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL gnt: got gnt_o=%b r_valid_o=%b expected gnt_o=%b", gnt_o, r_valid_o, e.vec);
          end else begin
            $display("gnt  gnt_o=%b addr=%h", gnt_o, master_add_o);
          end
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    req_i = '0; add_i = '0; we_i = '0; wdata_i = '0; be_i = '0;
    master_gnt_i = 1'b0; master_r_valid_i = 1'b0; master_r_rdata_i = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_master_req", 32'(master_req_o), 0);
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_r_valid", 32'(r_valid_o), 0);
    chk("rst_r_err", 32'(r_err_o), 0);
    cyc();
    rst_ni = 1'b1;

    // Fairness: both requesting, immediate grant; expect 0,1,0,1.
    add_i = {32'h0000_B000, 32'h0000_A000};
    for (int k = 0; k < 4; k++) begin
      cyc();
      req_i = 2'b11; master_gnt_i = 1'b1;
      master_r_valid_i = (k == 0);  // same-cycle r_valid with gnt is ignored
      master_r_rdata_i = 32'hFFFF_0000;
      push_gnt((k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk_i);
      chk("fair_addr", master_add_o, (k % 2 == 0) ? 32'h0000_A000 : 32'h0000_B000);
      cyc();
      master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h100 + 32'(k);
      push_rv((k % 2 == 0) ? 2'b01 : 2'b10, 32'h100 + 32'(k), 1'b0);
      @(negedge clk_i);
      chk("fair_wait_req", 32'(master_req_o), 0);
    end
    cyc();
    req_i = '0; master_r_valid_i = 1'b0;

    // Single write transaction from requester 0 (pointer is back at 0).
    cyc();
    req_i = 2'b01; add_i = {32'h0, 32'h0000_1000}; we_i = 2'b01;
    wdata_i = {32'h0, 32'h0000_55AA}; be_i = 8'h0F; master_gnt_i = 1'b1;
    push_gnt(2'b01);
    @(negedge clk_i);
    chk("single_req", 32'(master_req_o), 1);
    chk("single_addr", master_add_o, 32'h0000_1000);
    chk("single_we", 32'(master_we_o), 1);
    chk("single_wdata", master_wdata_o, 32'h0000_55AA);
    chk("single_be", 32'(master_be_o), 32'hF);
    cyc();
    req_i = '0; we_i = '0; master_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("single_busy", 32'(busy_o), 1);
    cyc(); cyc();
    cyc();
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0000_CAFE;
    push_rv(2'b01, 32'h0000_CAFE, 1'b0);
    cyc();
    master_r_valid_i = 1'b0;
    @(negedge clk_i);
    chk("single_idle", 32'(busy_o), 0);

    // Lock: pointer now favours requester 1, but req0 got there first.
    add_i = {32'h0000_3000, 32'h0000_2000};
    cyc();
    req_i = 2'b01;
    @(negedge clk_i);
    chk("lock_addr0", master_add_o, 32'h0000_2000);
    for (int k = 0; k < 3; k++) begin
      cyc();
      req_i = 2'b11;
      @(negedge clk_i);
      chk("lock_hold_addr", master_add_o, 32'h0000_2000);
      chk("lock_hold_req", 32'(master_req_o), 1);
    end
    cyc();
    master_gnt_i = 1'b1;
    push_gnt(2'b01);
    cyc();
    master_gnt_i = 1'b0; req_i = 2'b10;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0000_1111;
    push_rv(2'b01, 32'h0000_1111, 1'b0);
    cyc();
    master_r_valid_i = 1'b0; master_gnt_i = 1'b1;
    push_gnt(2'b10);
    @(negedge clk_i);
    chk("lock_next_addr", master_add_o, 32'h0000_3000);
    cyc();
    master_gnt_i = 1'b0; req_i = '0;
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'h0000_2222;
    push_rv(2'b10, 32'h0000_2222, 1'b0);
    cyc();
    master_r_valid_i = 1'b0;

    // Withdraw before grant.
    cyc();
    req_i = 2'b01;
    @(negedge clk_i);
    chk("wd_req", 32'(master_req_o), 1);
    cyc();
    req_i = 2'b00;
    @(negedge clk_i);
    chk("wd_req_drop", 32'(master_req_o), 0);
    chk("wd_busy_req", 32'(busy_o), 1);
    cyc();
    @(negedge clk_i);
    chk("wd_idle", 32'(busy_o), 0);

    // Stray response in Idle.
    cyc();
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEAD_0001;
    cyc();
    master_r_valid_i = 1'b0;

    // Reset while waiting for a response; the late response is a stray.
    cyc();
    req_i = 2'b01; master_gnt_i = 1'b1;
    push_gnt(2'b01);
    cyc();
    req_i = '0; master_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rstw_busy", 32'(busy_o), 1);
    cyc();
    rst_ni = 1'b0;
    #1;
    chk("rstw_busy_async", 32'(busy_o), 0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEAD_0002;
    cyc();
    master_r_valid_i = 1'b0;

`ifdef DM_SYSBUS_ARB_TIMEOUT_EN
    // Timeout after 8 Wait cycles (TimeoutCycles=8): error response, zero data.
    master_r_rdata_i = 32'hDEAD_BEEF;
    cyc();
    req_i = 2'b01; master_gnt_i = 1'b1;
    push_gnt(2'b01);
    for (int k = 0; k < 7; k++) begin
      cyc();
      req_i = '0; master_gnt_i = 1'b0;
      @(negedge clk_i);
      chk("to_no_err", 32'(r_err_o), 0);
    end
    cyc();
    push_rv(2'b01, 32'h0, 1'b1);
    cyc();
    master_r_valid_i = 1'b1;  // late response: dropped
    cyc();
    master_r_valid_i = 1'b0;
`endif

    cyc(); cyc();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
